// File: rtl/npu_instr_fetch.sv
// Instruction fetch/queue stage: streams a program from instruction memory, checks
// each word's prefix and queues good words for Control_Unit on a valid/ready port.
module npu_instr_fetch #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 4,
    parameter logic [3:0]  PREFIX = 4'b0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] instr_count,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [63:0]       imem_rdata,
    output logic              instr_valid,
    output logic [63:0]       instruction,
    input  logic              instr_ready,
    output logic              busy,
    output logic              done,
    output logic              err_prefix
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   base_q, count_q, issued_q;
    logic [CNT_W-1:0]    outst_q, fifo_cnt_q;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [63:0]         mem [DEPTH];

    logic                active_c, start_ok_c, ret_c, good_c, bad_c, pop_c, issue_c;
    logic [63:0]         head_next_c;

    always_comb begin
        active_c   = (state == FETCH) || (state == DRAIN);
        start_ok_c = start && ((state == IDLE) || (state == DONE));
        ret_c      = imem_rvalid && active_c;
        good_c     = ret_c && (imem_rdata[63:60] == PREFIX) && !err_prefix;
        bad_c      = ret_c && (imem_rdata[63:60] != PREFIX) && !err_prefix;
        pop_c      = instr_valid && instr_ready;
        // Capacity counts in-flight reads so a return can never find the FIFO full.
        issue_c    = (state == FETCH) && !bad_c && !err_prefix && (issued_q < count_q) &&
                     ((CNT_W+1)'(fifo_cnt_q) + (CNT_W+1)'(outst_q) < (CNT_W+1)'(DEPTH));
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (state == DONE) state_next = IDLE;
                if (start_ok_c) state_next = (instr_count == '0) ? DONE : FETCH;
            end
            FETCH: begin
                if (bad_c) state_next = DRAIN;
                else if (issue_c && (issued_q + ADDR_W'(1) == count_q)) state_next = DRAIN;
            end
            DRAIN: begin
                if ((outst_q == '0) && (fifo_cnt_q == '0)) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Head register tracks whatever word will sit at the FIFO head after this cycle.
    always_comb begin
        head_next_c = instruction;
        if (pop_c) begin
            if (fifo_cnt_q > CNT_W'(1)) head_next_c = mem[rd_ptr + PTR_W'(1)];
            else if (good_c)           head_next_c = imem_rdata;
        end else if ((fifo_cnt_q == '0) && good_c) begin
            head_next_c = imem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            base_q      <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            outst_q     <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr_valid <= 1'b0;
            instruction <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_prefix  <= 1'b0;
        end else begin
            state    <= state_next;
            busy     <= (state_next == FETCH) || (state_next == DRAIN);
            done     <= (state_next == DONE);
            imem_req <= issue_c;
            if (issue_c) imem_addr <= base_q + issued_q;
            if (start_ok_c) begin
                base_q   <= base_addr;
                count_q  <= instr_count;
                issued_q <= '0;
            end else if (issue_c) begin
                issued_q <= issued_q + ADDR_W'(1);
            end
            if (start_ok_c)  err_prefix <= 1'b0;
            else if (bad_c)  err_prefix <= 1'b1;
            outst_q     <= outst_q + CNT_W'(issue_c) - CNT_W'(ret_c);
            fifo_cnt_q  <= fifo_cnt_q + CNT_W'(good_c) - CNT_W'(pop_c);
            instr_valid <= (fifo_cnt_q + CNT_W'(good_c) - CNT_W'(pop_c)) != '0;
            instruction <= head_next_c;
            if (good_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // FIFO storage needs no reset; the counter decides what is valid.
    always_ff @(posedge clk) begin
        if (good_c) mem[wr_ptr] <= imem_rdata;
    end

endmodule
